led_fade_ctrl: RTL and testbench
================================

Name: led_fade_ctrl

Overview:
- Command-driven sequencer that produces the 8-bit duty cycle for a downstream pwm instance driving a status LED.
- Accepts one command at a time over a valid/ready handshake: set, ramp, breathe or off.
- Steps the duty at a fixed rate derived from an internal tick divider.
- Replaces ad-hoc fade logic in top-level designs; its dutyCycle output connects directly to pwm.dutyCycle.

Parameters:
CLK_FREQ, 12_000_000, input clock frequency in Hz
STEP_HZ, 500, duty step rate in Hz; DIV = CLK_FREQ/STEP_HZ (integer, must be >= 2)

Ports:
clk  input  1  system clock
nRst  input  1  synchronous active-low reset, sampled on rising edge of clk
enable  input  1  high: stepping runs; low: tick counter and stepping frozen, handshake still active
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_mode  input  2  0 SET, 1 RAMP, 2 BREATHE, 3 OFF
cmd_target  input  8  SET/RAMP target; BREATHE upper bound
cmd_low  input  8  BREATHE lower bound (ignored in other modes)
dutyCycle  output  8  duty to pwm, registered
busy  output  1  high in RAMP, BREATHE_UP and BREATHE_DOWN
done  output  1  one-cycle pulse on SET/OFF/RAMP completion

Behaviour:
- Reset (nRst=0 at a clk edge): dutyCycle=0, state IDLE, tick counter=0, done=0, busy=0. cmd_ready=0 during the reset cycle and 1 from the first cycle after reset.
- Accept occurs when cmd_valid & cmd_ready. All command fields are latched on the accept edge.
- cmd_ready is combinational from state: 1 in IDLE, BREATHE_UP and BREATHE_DOWN; 0 in RAMP. Breathe is abortable; a ramp is not.
- Tick generator: counter 0..DIV-1 that advances only when enable=1.
  - tick asserts for one cycle when counter==DIV-1 and enable=1; counter then wraps to 0.
  - Counter is cleared on every accept, so the first step occurs DIV enabled cycles after the accept.
- States and transitions:
  - IDLE:
    - Accept SET: dutyCycle<=cmd_target, done<=1 on the same edge; stay IDLE.
    - Accept OFF: dutyCycle<=0, done<=1; stay IDLE.
    - Accept RAMP with cmd_target==dutyCycle: done<=1; stay IDLE.
    - Accept RAMP otherwise: go to RAMP.
    - Accept BREATHE with cmd_low>=cmd_target: treat as SET to cmd_target (done pulses, IDLE).
    - Accept BREATHE otherwise: go to BREATHE_UP if dutyCycle<cmd_target, else BREATHE_DOWN. No done pulse.
  - RAMP: each tick moves dutyCycle by 1 toward the target. On the tick where the new value equals the target, done<=1 on the same edge and the state returns to IDLE.
  - BREATHE_UP: each tick dutyCycle+1; when the new value == high, go to BREATHE_DOWN.
  - BREATHE_DOWN: each tick dutyCycle-1; when the new value == low, go to BREATHE_UP. A duty above high at entry descends normally.
  - A new accept in BREATHE_* is handled exactly as from IDLE, starting from the current dutyCycle with no glitch.
- Arithmetic: dutyCycle never wraps. Steps are only taken toward a bound that is strictly beyond the current value, so 0-1 and 255+1 cannot occur.
- Latency: SET/OFF appear on dutyCycle 1 clk after the accept edge. A ramp of N steps completes in N*DIV enabled cycles after accept.
- Simultaneous events:
  - An accept on a tick cycle is handled as an accept; the tick is discarded and the counter is cleared.
  - enable=0 during RAMP freezes both dutyCycle and the counter; they resume from the same count.
- done is never asserted in the same cycle as another done; it is 0 in every cycle other than a completion edge.
- A reset mid-ramp or mid-breathe returns all outputs to their reset values on that edge; in-flight command state is discarded.

Test Plan:
- Reset, then SET target=0x80 -> dutyCycle=0x80 and done=1 one cycle after accept, busy=0, cmd_ready=1.
- CLK_FREQ=1000, STEP_HZ=100 (DIV=10), duty=0x10, RAMP target=0x14 -> dutyCycle 0x11..0x14 at 10-cycle intervals; done coincides with 0x14 at cycle 40 after accept; cmd_ready=0 throughout the ramp; cmd_valid held during the ramp is accepted only after IDLE.
- BREATHE low=0x02 high=0x05 from duty 0 -> sequence 1,2,3,4,5,4,3,2,3,4,5,... one step per tick; no done pulses; busy=1.
- During breathe, OFF command -> dutyCycle=0 next cycle, done=1, busy=0; BREATHE low=0x09 high=0x09 -> behaves as SET 0x09.
- Mid-RAMP, drop enable for 25 cycles -> dutyCycle and step timing shifted by exactly 25 cycles; no step lost or doubled.
- Mid-RAMP, nRst=0 for one cycle -> dutyCycle=0, busy=0, done=0, cmd_ready=0 that cycle and 1 the next.

Source files
------------

// File: rtl/led_fade_ctrl.sv
// rtl/led_fade_ctrl.sv - command-driven LED duty sequencer (set/ramp/breathe/off) feeding a pwm dutyCycle input
module led_fade_ctrl #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int STEP_HZ  = 500
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_low,
  output logic [7:0] dutyCycle,
  output logic       busy,
  output logic       done
);

  localparam int DIV = CLK_FREQ / STEP_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] MODE_SET  = 2'd0;
  localparam logic [1:0] MODE_RAMP = 2'd1;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  typedef enum logic [1:0] {IDLE, RAMP, BREATHE_UP, BREATHE_DOWN} state_t;

  state_t           state;
  logic [CNT_W-1:0] tickCnt;
  logic [7:0]       target;
  logic [7:0]       low;
  logic             accept;
  logic             tick;
  logic [7:0]       dutyInc;
  logic [7:0]       dutyDec;
  logic [7:0]       rampNext;

  // A ramp cannot be interrupted; breathe can be replaced at any time.
  assign cmd_ready = nRst && (state != RAMP);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = enable && (tickCnt == CNT_MAX);

  assign dutyInc  = dutyCycle + 8'd1;
  assign dutyDec  = dutyCycle - 8'd1;
  assign rampNext = (target > dutyCycle) ? dutyInc : dutyDec;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state     <= IDLE;
      dutyCycle <= 8'd0;
      tickCnt   <= '0;
      target    <= 8'd0;
      low       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Accept wins over a coincident tick and restarts the step period.
        tickCnt <= '0;
        target  <= cmd_target;
        low     <= cmd_low;
        case (cmd_mode)
          MODE_SET: begin
            dutyCycle <= cmd_target;
            done      <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
          MODE_OFF: begin
            dutyCycle <= 8'd0;
            done      <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
          MODE_RAMP: begin
            if (cmd_target == dutyCycle) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
          default: begin
            if (cmd_low >= cmd_target) begin
              dutyCycle <= cmd_target;
              done      <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else if (dutyCycle < cmd_target) begin
              state <= BREATHE_UP;
              busy  <= 1'b1;
            end else begin
              state <= BREATHE_DOWN;
              busy  <= 1'b1;
            end
          end
        endcase
      end else if (enable) begin
        if (tick) begin
          tickCnt <= '0;
          case (state)
            RAMP: begin
              dutyCycle <= rampNext;
              if (rampNext == target) begin
                done  <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
            BREATHE_UP: begin
              dutyCycle <= dutyInc;
              if (dutyInc == target) state <= BREATHE_DOWN;
            end
            BREATHE_DOWN: begin
              dutyCycle <= dutyDec;
              if (dutyDec == low) state <= BREATHE_UP;
            end
            default: ;
          endcase
        end else begin
          tickCnt <= tickCnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// tb/tb_led_fade_ctrl.sv - directed and randomized checks of led_fade_ctrl against a behavioural model
module tb_led_fade_ctrl;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       enable = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_target = 8'd0;
  logic [7:0] cmd_low = 8'd0;
  logic [7:0] dutyCycle;
  logic       busy;
  logic       done;

  int nAssert = 0;
  int nFail = 0;

  // Model: phase 0 idle, 1 ramping, 2 rising breath, 3 falling breath.
  int mDuty = 0;
  int mPhase = 0;
  int mHigh = 0;
  int mLow = 0;
  int mSince = 0;
  bit mDone = 1'b0;

  int bseq[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5};

  led_fade_ctrl #(.CLK_FREQ(1000), .STEP_HZ(100)) dut (
    .clk(clk), .nRst(nRst), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_target(cmd_target),
    .cmd_low(cmd_low), .dutyCycle(dutyCycle), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelAccept();
    mSince = 0;
    case (int'(cmd_mode))
      0: begin mDuty = int'(cmd_target); mDone = 1; mPhase = 0; end
      3: begin mDuty = 0; mDone = 1; mPhase = 0; end
      1: begin
        mHigh = int'(cmd_target);
        if (mHigh == mDuty) begin mDone = 1; mPhase = 0; end
        else mPhase = 1;
      end
      default: begin
        if (int'(cmd_low) >= int'(cmd_target)) begin
          mDuty = int'(cmd_target); mDone = 1; mPhase = 0;
        end else begin
          mHigh = int'(cmd_target);
          mLow = int'(cmd_low);
          mPhase = (mDuty < mHigh) ? 2 : 3;
        end
      end
    endcase
  endtask

  task automatic modelStep();
    if (mPhase == 1) begin
      mDuty = mDuty + ((mHigh > mDuty) ? 1 : -1);
      if (mDuty == mHigh) begin mDone = 1; mPhase = 0; end
    end else if (mPhase == 2) begin
      mDuty++;
      if (mDuty == mHigh) mPhase = 3;
    end else if (mPhase == 3) begin
      mDuty--;
      if (mDuty == mLow) mPhase = 2;
    end
  endtask

  // Advance the model over one clock edge using the inputs present now, then compare.
  task automatic cycle();
    if (!nRst) begin
      mDuty = 0; mPhase = 0; mSince = 0; mDone = 0;
    end else begin
      mDone = 0;
      if (cmd_valid && mPhase != 1) modelAccept();
      else if (enable) begin
        mSince++;
        if (mSince == DIV) begin
          mSince = 0;
          modelStep();
        end
      end
    end
    @(posedge clk);
    #1;
    chk("model duty", 32'(dutyCycle), 32'(mDuty));
    chk("model done", 32'(done), 32'(mDone));
    chk("model busy", 32'(busy), 32'(mPhase != 0));
    chk("model ready", 32'(cmd_ready), 32'(nRst && mPhase != 1));
  endtask

  task automatic sendCmd(input logic [1:0] m, input logic [7:0] t, input logic [7:0] l);
    cmd_valid = 1'b1; cmd_mode = m; cmd_target = t; cmd_low = l;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    cycle();
    chk("reset duty", 32'(dutyCycle), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset ready", 32'(cmd_ready), 32'h0);
    nRst = 1'b1;
    #1;
    chk("ready after reset", 32'(cmd_ready), 32'h1);
    cycle();

    sendCmd(2'd0, 8'h80, 8'h00);
    chk("set duty", 32'(dutyCycle), 32'h80);
    chk("set done", 32'(done), 32'h1);
    chk("set busy", 32'(busy), 32'h0);
    chk("set ready", 32'(cmd_ready), 32'h1);
    cycle();
    chk("set done pulse", 32'(done), 32'h0);

    sendCmd(2'd0, 8'h10, 8'h00);
    cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_target = 8'h14;
    cycle();
    chk("ramp busy", 32'(busy), 32'h1);
    chk("ramp ready", 32'(cmd_ready), 32'h0);
    cmd_mode = 2'd0; cmd_target = 8'h33;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      chk("ramp duty", 32'(dutyCycle), 32'(8'h10 + i / 10));
      chk("ramp done", 32'(done), 32'(i == 40));
      chk("ramp ready hold", 32'(cmd_ready), 32'(i == 40));
    end
    cycle();
    chk("held cmd accepted", 32'(dutyCycle), 32'h33);
    cmd_valid = 1'b0;

    sendCmd(2'd3, 8'h00, 8'h00);
    chk("off duty", 32'(dutyCycle), 32'h0);
    sendCmd(2'd2, 8'h05, 8'h02);
    for (int i = 1; i <= 110; i++) begin
      cycle();
      chk("breathe duty", 32'(dutyCycle), 32'((i < 10) ? 0 : bseq[i / 10 - 1]));
      chk("breathe done", 32'(done), 32'h0);
      chk("breathe busy", 32'(busy), 32'h1);
    end
    sendCmd(2'd3, 8'h00, 8'h00);
    chk("breathe off duty", 32'(dutyCycle), 32'h0);
    chk("breathe off done", 32'(done), 32'h1);
    chk("breathe off busy", 32'(busy), 32'h0);
    sendCmd(2'd2, 8'h09, 8'h09);
    chk("flat breathe duty", 32'(dutyCycle), 32'h9);
    chk("flat breathe done", 32'(done), 32'h1);
    chk("flat breathe busy", 32'(busy), 32'h0);

    sendCmd(2'd0, 8'h10, 8'h00);
    sendCmd(2'd1, 8'h12, 8'h00);
    for (int i = 1; i <= 50; i++) begin
      enable = (i <= 15) || (i > 40);
      cycle();
      chk("pause duty", 32'(dutyCycle), 32'((i < 10) ? 8'h10 : (i < 45) ? 8'h11 : 8'h12));
      chk("pause done", 32'(done), 32'(i == 45));
    end
    enable = 1'b1;

    sendCmd(2'd1, 8'h30, 8'h00);
    for (int i = 0; i < 25; i++) cycle();
    nRst = 1'b0;
    cycle();
    chk("midramp reset duty", 32'(dutyCycle), 32'h0);
    chk("midramp reset busy", 32'(busy), 32'h0);
    chk("midramp reset done", 32'(done), 32'h0);
    chk("midramp reset ready", 32'(cmd_ready), 32'h0);
    nRst = 1'b1;
    #1;
    chk("midramp ready after", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      nRst = ($urandom_range(0, 499) != 0);
      enable = ($urandom_range(0, 9) != 0);
      cmd_valid = ($urandom_range(0, 19) == 0);
      cmd_mode = 2'($urandom_range(0, 3));
      cmd_target = 8'($urandom_range(0, 30));
      cmd_low = 8'($urandom_range(0, 30));
      cycle();
    end
    nRst = 1'b1;
    cmd_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
